// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, R-type function
// codes, ALU control values, ALU-op classes and FSM states.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_LBRD    = 4'd3,
    S_LBWR    = 4'd4,
    S_SBWR    = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWR = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_JEX     = 4'd10,
    S_ADDIEX  = 4'd11,
    S_ADDIWR  = 4'd12
  } state_t;

  // Successor of DECODE; S_FETCH means the opcode is not decodable.
  function automatic state_t decode_target(input logic [5:0] op, input logic en_ext);
    state_t nxt;
    nxt = S_FETCH;
    case (op)
      OP_LB, OP_SB: nxt = S_MEMADR;
      OP_RTYPE:     nxt = S_RTYPEEX;
      OP_BEQ:       nxt = S_BEQEX;
      OP_J:         nxt = S_JEX;
      OP_BNE:       nxt = en_ext ? S_BNEEX : S_FETCH;
      OP_ADDI:      nxt = en_ext ? S_ADDIEX : S_FETCH;
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU control decoder: maps the controller's ALU-op class and the R-type
// function field onto the ALU operation code.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucont,
  output logic       illegal_funct
);

  always_comb begin
    alucont       = ALU_ADD;
    illegal_funct = 1'b0;
    case (aluop_t'(aluop))
      ALUOP_ADD: alucont = ALU_ADD;
      ALUOP_SUB: alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucont = ALU_ADD;
          FN_SUB:  alucont = ALU_SUB;
          FN_AND:  alucont = ALU_AND;
          FN_OR:   alucont = ALU_OR;
          FN_SLT:  alucont = ALU_SLT;
          default: begin
            // Unknown function: keep the ALU on a harmless add.
            alucont       = ALU_ADD;
            illegal_funct = 1'b1;
          end
        endcase
      end
      default: alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller with a byte-serial instruction fetch.
// State and fetch beat are exposed on dbg_state / dbg_beat.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int IR_BYTES = 4,
  parameter bit EN_EXT   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                memready,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic                branch,
  output logic                branchne,
  output logic                iord,
  output logic                memwrite,
  output logic                memtoreg,
  output logic                pcwrite,
  output logic                regwrite,
  output logic                regdst,
  output logic [IR_BYTES-1:0] irwrite,
  output logic [1:0]          pcsource,
  output logic [2:0]          alucont,
  output logic                illegal,
  output state_t              dbg_state,
  output logic [2:0]          dbg_beat
);

  localparam logic [2:0] K_LAST = 3'(IR_BYTES - 1);

  state_t              r_state;
  logic [2:0]          r_k;
  logic                r_is_sb;
  logic [1:0]          w_aluop;
  logic                w_illegal_funct;
  logic [IR_BYTES-1:0] w_onehot;
  state_t              w_decode_nxt;

  assign w_onehot     = IR_BYTES'(1) << r_k;
  assign w_decode_nxt = decode_target(op, EN_EXT);
  assign dbg_state    = r_state;
  assign dbg_beat     = r_k;

  // LB/SB is latched in DECODE so MEMADR never looks at op again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_k     <= 3'd0;
      r_is_sb <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (memready) begin
            if (r_k == K_LAST) begin
              r_k     <= 3'd0;
              r_state <= S_DECODE;
            end else begin
              r_k <= r_k + 3'd1;
            end
          end
        end
        S_DECODE: begin
          r_is_sb <= (op == OP_SB);
          r_k     <= 3'd0;
          r_state <= w_decode_nxt;
        end
        S_MEMADR:  r_state <= r_is_sb ? S_SBWR : S_LBRD;
        S_LBRD:    if (memready) r_state <= S_LBWR;
        S_SBWR:    if (memready) r_state <= S_FETCH;
        S_RTYPEEX: r_state <= S_RTYPEWR;
        S_ADDIEX:  r_state <= S_ADDIWR;
        S_LBWR, S_RTYPEWR, S_BEQEX, S_BNEEX, S_JEX, S_ADDIWR: r_state <= S_FETCH;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    branch   = 1'b0;
    branchne = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    pcwrite  = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    irwrite  = '0;
    pcsource = 2'b00;
    illegal  = 1'b0;
    w_aluop  = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        pcwrite = memready;
        irwrite = memready ? w_onehot : '0;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal = (w_decode_nxt == S_FETCH);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_LBRD: iord = 1'b1;
      S_SBWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
        illegal = w_illegal_funct;
      end
      S_RTYPEWR: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsource = 2'b01;
        branch   = 1'b1;
      end
      S_BNEEX: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsource = 2'b01;
        branchne = 1'b1;
      end
      S_JEX: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWR: regwrite = 1'b1;
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop         (w_aluop),
    .funct         (funct),
    .alucont       (alucont),
    .illegal_funct (w_illegal_funct)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: three instances (4-byte/ext,
// 4-byte/no-ext, 2-byte/ext) share inputs; one is selected per scenario.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       memready;

  logic       ill [3];
  logic       asa [3];
  logic [1:0] asb [3];
  logic       br [3];
  logic       bne [3];
  logic       iord [3];
  logic       mw [3];
  logic       mtr [3];
  logic       pcw [3];
  logic       rw [3];
  logic       rd [3];
  logic [1:0] pcs [3];
  logic [2:0] alu [3];
  state_t     st [3];
  logic [2:0] bt [3];
  logic [3:0] irw0;
  logic [3:0] irw1;
  logic [1:0] irw2;
  logic [24:0] v [3];

  logic [26:0] exp_q[$];
  string       name_q[$];
  logic [1:0]  cur_sel;
  int          tests;
  int          fails;
  bit          done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl #(.IR_BYTES(4), .EN_EXT(1'b1)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .memready(memready),
    .alusrca(asa[0]), .alusrcb(asb[0]), .branch(br[0]), .branchne(bne[0]),
    .iord(iord[0]), .memwrite(mw[0]), .memtoreg(mtr[0]), .pcwrite(pcw[0]),
    .regwrite(rw[0]), .regdst(rd[0]), .irwrite(irw0), .pcsource(pcs[0]),
    .alucont(alu[0]), .illegal(ill[0]), .dbg_state(st[0]), .dbg_beat(bt[0]));

  multicycle_ctrl #(.IR_BYTES(4), .EN_EXT(1'b0)) dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .memready(memready),
    .alusrca(asa[1]), .alusrcb(asb[1]), .branch(br[1]), .branchne(bne[1]),
    .iord(iord[1]), .memwrite(mw[1]), .memtoreg(mtr[1]), .pcwrite(pcw[1]),
    .regwrite(rw[1]), .regdst(rd[1]), .irwrite(irw1), .pcsource(pcs[1]),
    .alucont(alu[1]), .illegal(ill[1]), .dbg_state(st[1]), .dbg_beat(bt[1]));

  multicycle_ctrl #(.IR_BYTES(2), .EN_EXT(1'b1)) dut2 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .memready(memready),
    .alusrca(asa[2]), .alusrcb(asb[2]), .branch(br[2]), .branchne(bne[2]),
    .iord(iord[2]), .memwrite(mw[2]), .memtoreg(mtr[2]), .pcwrite(pcw[2]),
    .regwrite(rw[2]), .regdst(rd[2]), .irwrite(irw2), .pcsource(pcs[2]),
    .alucont(alu[2]), .illegal(ill[2]), .dbg_state(st[2]), .dbg_beat(bt[2]));

  assign v[0] = {ill[0], asa[0], asb[0], br[0], bne[0], iord[0], mw[0], mtr[0],
                 pcw[0], rw[0], rd[0], pcs[0], alu[0], {4'b0, irw0}};
  assign v[1] = {ill[1], asa[1], asb[1], br[1], bne[1], iord[1], mw[1], mtr[1],
                 pcw[1], rw[1], rd[1], pcs[1], alu[1], {4'b0, irw1}};
  assign v[2] = {ill[2], asa[2], asb[2], br[2], bne[2], iord[2], mw[2], mtr[2],
                 pcw[2], rw[2], rd[2], pcs[2], alu[2], {6'b0, irw2}};

  // Field order: illegal, alusrca, alusrcb, branch, branchne, iord, memwrite,
  // memtoreg, pcwrite, regwrite, regdst, pcsource, alucont, irwrite(8).
  function automatic logic [24:0] ev(input logic il, input logic sa, input logic [1:0] sb,
                                     input logic b, input logic bn, input logic io,
                                     input logic w, input logic m, input logic p,
                                     input logic r, input logic d, input logic [1:0] ps,
                                     input logic [2:0] a, input logic [7:0] ir);
    return {il, sa, sb, b, bn, io, w, m, p, r, d, ps, a, ir};
  endfunction

  function automatic logic [24:0] e_fetch(input logic [7:0] ir);
    return ev(0, 0, 2'b01, 0, 0, 0, 0, 0, |ir, 0, 0, 2'b00, 3'b010, ir);
  endfunction
  function automatic logic [24:0] e_decode(input logic il);
    return ev(il, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 8'h00);
  endfunction
  function automatic logic [24:0] e_rtex(input logic [2:0] a, input logic il);
    return ev(il, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, a, 8'h00);
  endfunction

  localparam logic [24:0] E_MEMADR = {1'b0, 1'b1, 2'b10, 8'b0, 2'b00, 3'b010, 8'h00};
  localparam logic [24:0] E_LBRD   = {1'b0, 1'b0, 2'b00, 4'b0010, 4'b0000, 2'b00, 3'b010, 8'h00};
  localparam logic [24:0] E_SBWR   = {1'b0, 1'b0, 2'b00, 4'b0011, 4'b0000, 2'b00, 3'b010, 8'h00};
  localparam logic [24:0] E_LBWR   = {1'b0, 1'b0, 2'b00, 4'b0000, 4'b1010, 2'b00, 3'b010, 8'h00};
  localparam logic [24:0] E_RTWR   = {1'b0, 1'b0, 2'b00, 4'b0000, 4'b0011, 2'b00, 3'b010, 8'h00};
  localparam logic [24:0] E_BEQ    = {1'b0, 1'b1, 2'b00, 4'b1000, 4'b0000, 2'b01, 3'b110, 8'h00};
  localparam logic [24:0] E_BNE    = {1'b0, 1'b1, 2'b00, 4'b0100, 4'b0000, 2'b01, 3'b110, 8'h00};
  localparam logic [24:0] E_JEX    = {1'b0, 1'b0, 2'b00, 4'b0000, 4'b0100, 2'b10, 3'b010, 8'h00};
  localparam logic [24:0] E_ADDIEX = {1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 2'b00, 3'b010, 8'h00};
  localparam logic [24:0] E_ADDIWR = {1'b0, 1'b0, 2'b00, 4'b0000, 4'b0010, 2'b00, 3'b010, 8'h00};

  // Monitor: compares the selected instance mid-cycle.
  always @(negedge clk) begin
    logic [26:0] w;
    string       nm;
    if (exp_q.size() > 0) begin
      w  = exp_q.pop_front();
      nm = name_q.pop_front();
      tests++;
      if (v[w[26:25]] !== w[24:0]) begin
        fails++;
        $display("FAIL %s dut%0d got=%h exp=%h at %0t", nm, w[26:25], v[w[26:25]], w[24:0], $time);
      end
    end
  end

  initial begin
    done = 1'b0;
    #100000;
    if (!done) begin
      fails++;
      $display("FAIL timeout: stimulus did not complete at %0t", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic check_now(input logic [24:0] e, input string nm);
    tests++;
    if (v[cur_sel] !== e) begin
      fails++;
      $display("FAIL %s dut%0d got=%h exp=%h at %0t", nm, cur_sel, v[cur_sel], e, $time);
    end
  endtask

  task automatic step(input logic [5:0] o, input logic [5:0] f, input logic mr,
                      input logic [24:0] e, input string nm);
    op       = o;
    funct    = f;
    memready = mr;
    exp_q.push_back({cur_sel, e});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_all(input int n, input logic [5:0] o, input string nm);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(1) << i;
      step(o, 6'd0, 1'b1, e_fetch(b), nm);
    end
  endtask

  task automatic do_reset(input logic [1:0] s);
    cur_sel  = s;
    memready = 1'b0;
    reset    = 1'b1;
    #1;
    check_now(e_fetch(8'h00), "reset_immediate");
    step(6'd0, 6'd0, 1'b0, e_fetch(8'h00), "reset");
    reset   = 1'b0;
  endtask

  logic [5:0] rt_fn [6];
  logic [2:0] rt_alu [6];
  logic       rt_ill [6];

  initial begin
    tests    = 0;
    fails    = 0;
    cur_sel  = 2'd0;
    reset    = 1'b1;
    op       = 6'd0;
    funct    = 6'd0;
    memready = 1'b0;
    rt_fn  = '{FN_SUB, 6'b111111, FN_ADD, FN_AND, FN_OR, FN_SLT};
    rt_alu = '{3'b110, 3'b010, 3'b010, 3'b000, 3'b001, 3'b111};
    rt_ill = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    @(posedge clk);
    #1;

    do_reset(2'd0);
    // LB; op is scrambled after DECODE and must be ignored.
    fetch_all(4, OP_LB, "lb_fetch");
    step(OP_LB, 6'd0, 1'b1, e_decode(1'b0), "lb_decode");
    step(OP_SB, 6'd0, 1'b1, E_MEMADR, "lb_memadr");
    step(OP_SB, 6'd0, 1'b1, E_LBRD, "lb_rd");
    step(OP_SB, 6'd0, 1'b1, E_LBWR, "lb_wr");
    step(OP_SB, 6'd0, 1'b0, e_fetch(8'h00), "lb_back");

    // SB with memready stalled three cycles in SBWR.
    fetch_all(4, OP_SB, "sb_fetch");
    step(OP_SB, 6'd0, 1'b1, e_decode(1'b0), "sb_decode");
    step(OP_LB, 6'd0, 1'b1, E_MEMADR, "sb_memadr");
    for (int i = 0; i < 3; i++) step(OP_LB, 6'd0, 1'b0, E_SBWR, "sb_wait");
    step(OP_LB, 6'd0, 1'b1, E_SBWR, "sb_done");
    step(OP_LB, 6'd0, 1'b0, e_fetch(8'h00), "sb_back");

    for (int i = 0; i < 6; i++) begin
      fetch_all(4, OP_RTYPE, "rt_fetch");
      step(OP_RTYPE, rt_fn[i], 1'b1, e_decode(1'b0), "rt_decode");
      step(OP_J, rt_fn[i], 1'b1, e_rtex(rt_alu[i], rt_ill[i]), "rt_ex");
      step(OP_J, 6'b111111, 1'b1, E_RTWR, "rt_wr");
    end

    fetch_all(4, OP_BEQ, "beq_fetch");
    step(OP_BEQ, 6'd0, 1'b1, e_decode(1'b0), "beq_decode");
    step(OP_BEQ, 6'd0, 1'b1, E_BEQ, "beq_ex");
    fetch_all(4, OP_BNE, "bne_fetch");
    step(OP_BNE, 6'd0, 1'b1, e_decode(1'b0), "bne_decode");
    step(OP_BNE, 6'd0, 1'b1, E_BNE, "bne_ex");
    fetch_all(4, OP_ADDI, "addi_fetch");
    step(OP_ADDI, 6'd0, 1'b1, e_decode(1'b0), "addi_decode");
    step(OP_ADDI, 6'd0, 1'b1, E_ADDIEX, "addi_ex");
    step(OP_ADDI, 6'd0, 1'b1, E_ADDIWR, "addi_wr");
    // Undefined opcode, then a full J proving fetch restarted at beat 0.
    fetch_all(4, 6'b111111, "bad_fetch");
    step(6'b111111, 6'd0, 1'b1, e_decode(1'b1), "bad_decode");
    fetch_all(4, OP_J, "j_fetch");
    step(OP_J, 6'd0, 1'b1, e_decode(1'b0), "j_decode");
    step(OP_J, 6'd0, 1'b1, E_JEX, "j_ex");

    do_reset(2'd1);
    fetch_all(4, OP_ADDI, "noext_fetch");
    step(OP_ADDI, 6'd0, 1'b1, e_decode(1'b1), "noext_addi");
    fetch_all(4, OP_BNE, "noext_fetch2");
    step(OP_BNE, 6'd0, 1'b1, e_decode(1'b1), "noext_bne");
    fetch_all(4, OP_BEQ, "noext_fetch3");
    step(OP_BEQ, 6'd0, 1'b1, e_decode(1'b0), "noext_beq_dec");
    step(OP_BEQ, 6'd0, 1'b1, E_BEQ, "noext_beq_ex");

    do_reset(2'd2);
    fetch_all(2, OP_J, "ir2_j_fetch");
    step(OP_J, 6'd0, 1'b1, e_decode(1'b0), "ir2_j_decode");
    step(OP_J, 6'd0, 1'b1, E_JEX, "ir2_j_ex");
    step(OP_LB, 6'd0, 1'b0, e_fetch(8'h00), "ir2_stall");
    fetch_all(2, OP_LB, "ir2_lb_fetch");
    step(OP_LB, 6'd0, 1'b1, e_decode(1'b0), "ir2_lb_decode");
    step(OP_LB, 6'd0, 1'b1, E_MEMADR, "ir2_lb_memadr");
    step(OP_LB, 6'd0, 1'b0, E_LBRD, "ir2_lb_rd");
    // Reset lands mid-cycle in LBRD; outputs must fall back before any edge.
    memready = 1'b0;
    reset    = 1'b1;
    #1;
    check_now(e_fetch(8'h00), "rst_mid_lbrd_now");
    step(OP_LB, 6'd0, 1'b0, e_fetch(8'h00), "rst_mid_lbrd");
    reset = 1'b0;
    fetch_all(2, OP_J, "ir2_after_rst");
    step(OP_J, 6'd0, 1'b1, e_decode(1'b0), "ir2_after_dec");

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
